// File: rtl/uart_bcd_word_assembler_if.sv
// Byte-in / BCD-word-out bundle between the UART receiver side (master) and
// the word assembler (slave).
interface uart_bcd_word_assembler_if #(
  parameter int N_DIGITS = 3
);
  localparam int W  = 4 * N_DIGITS;
  localparam int CW = $clog2(N_DIGITS + 1);

  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          flush;
  logic [W-1:0]  word_data;
  logic          word_valid;
  logic          digit_error;
  logic          timeout_error;
  logic          busy;
  logic [CW-1:0] digit_count;

  modport master (
    output byte_valid, byte_data, flush,
    input  word_data, word_valid, digit_error, timeout_error, busy, digit_count
  );

  modport slave (
    input  byte_valid, byte_data, flush,
    output word_data, word_valid, digit_error, timeout_error, busy, digit_count
  );
endinterface

// File: rtl/uart_bcd_word_assembler.sv
// Packs one decimal digit per received byte into an N_DIGITS BCD word with
// validation, optional timeout and flush; word_data only moves on completion.
module uart_bcd_word_assembler #(
  parameter int N_DIGITS       = 3,
  parameter int MSD_FIRST      = 0,
  parameter int ASCII_MODE     = 0,
  parameter int TIMEOUT_CYCLES = 0
) (
  input logic                        clk,
  input logic                        rst,
  uart_bcd_word_assembler_if.slave   bus_if
);
  localparam int W  = 4 * N_DIGITS;
  localparam int CW = $clog2(N_DIGITS + 1);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic {IDLE, COLLECT} state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  partial_q, partial_d;
  logic [W-1:0]  word_q, word_d;
  logic [CW-1:0] count_q, count_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          word_valid_q, word_valid_d;
  logic          digit_err_q, digit_err_d;
  logic          timeout_err_q, timeout_err_d;

  logic [3:0]    digit;
  logic          digit_ok;
  logic [W-1:0]  merged;

  assign digit    = bus_if.byte_data[3:0];
  assign digit_ok = (digit <= 4'd9) &&
                    ((ASCII_MODE == 0) || (bus_if.byte_data[7:4] == 4'h3));

  // Partial register with the incoming digit dropped into slot count_q.
  // Every return to IDLE clears partial_q and count_q, so slot 0 is correct there.
  always_comb begin
    merged = partial_q;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (count_q == CW'(i)) begin
        merged[((MSD_FIRST != 0) ? (N_DIGITS - 1 - i) : i) * 4 +: 4] = digit;
      end
    end
  end

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    partial_d     = partial_q;
    count_d       = count_q;
    timer_d       = timer_q;
    word_d        = word_q;
    word_valid_d  = 1'b0;
    digit_err_d   = 1'b0;
    timeout_err_d = 1'b0;

    if (bus_if.flush) begin
      state_d   = IDLE;
      partial_d = '0;
      count_d   = '0;
      timer_d   = '0;
    end else if (bus_if.byte_valid) begin
      timer_d = '0;
      if (!digit_ok) begin
        digit_err_d = 1'b1;
        state_d     = IDLE;
        partial_d   = '0;
        count_d     = '0;
      end else if (count_q == CW'(N_DIGITS - 1)) begin
        word_d       = merged;
        word_valid_d = 1'b1;
        state_d      = IDLE;
        partial_d    = '0;
        count_d      = '0;
      end else begin
        partial_d = merged;
        count_d   = count_q + 1'b1;
        state_d   = COLLECT;
      end
    end else if ((TIMEOUT_CYCLES > 0) && (state_q == COLLECT)) begin
      if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
        timeout_err_d = 1'b1;
        state_d       = IDLE;
        partial_d     = '0;
        count_d       = '0;
        timer_d       = '0;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      partial_q     <= '0;
      word_q        <= '0;
      count_q       <= '0;
      timer_q       <= '0;
      word_valid_q  <= 1'b0;
      digit_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      partial_q     <= partial_d;
      word_q        <= word_d;
      count_q       <= count_d;
      timer_q       <= timer_d;
      word_valid_q  <= word_valid_d;
      digit_err_q   <= digit_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus_if.word_data     = word_q;
  assign bus_if.word_valid    = word_valid_q;
  assign bus_if.digit_error   = digit_err_q;
  assign bus_if.timeout_error = timeout_err_q;
  assign bus_if.busy          = (state_q == COLLECT);
  assign bus_if.digit_count   = count_q;
endmodule

// File: tb/tb_uart_bcd_word_assembler.sv
// Directed bench for three assembler configurations; completed words are
// predicted into per-DUT queues and matched when word_valid pulses.
module tb_uart_bcd_word_assembler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  uart_bcd_word_assembler_if #(.N_DIGITS(3)) if_a ();
  uart_bcd_word_assembler_if #(.N_DIGITS(4)) if_b ();
  uart_bcd_word_assembler_if #(.N_DIGITS(3)) if_c ();

  uart_bcd_word_assembler dut_a (.clk(clk), .rst(rst), .bus_if(if_a));

  uart_bcd_word_assembler #(
    .N_DIGITS(4), .MSD_FIRST(1), .ASCII_MODE(1), .TIMEOUT_CYCLES(0)
  ) dut_b (.clk(clk), .rst(rst), .bus_if(if_b));

  uart_bcd_word_assembler #(
    .N_DIGITS(3), .MSD_FIRST(0), .ASCII_MODE(0), .TIMEOUT_CYCLES(8)
  ) dut_c (.clk(clk), .rst(rst), .bus_if(if_c));

  logic [11:0] q_a[$];
  logic [15:0] q_b[$];
  logic [11:0] q_c[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic drive_a(input logic [7:0] d, input logic f);
    if_a.byte_valid = 1'b1;
    if_a.byte_data  = d;
    if_a.flush      = f;
    tick();
    if_a.byte_valid = 1'b0;
    if_a.flush      = 1'b0;
  endtask

  task automatic drive_b(input logic [7:0] d);
    if_b.byte_valid = 1'b1;
    if_b.byte_data  = d;
    tick();
    if_b.byte_valid = 1'b0;
  endtask

  task automatic drive_c(input logic [7:0] d);
    if_c.byte_valid = 1'b1;
    if_c.byte_data  = d;
    tick();
    if_c.byte_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (if_a.word_valid) begin
      if (q_a.size() == 0) check("a_unexpected_word", {31'd0, if_a.word_valid}, 32'd0);
      else                 check("a_word", {20'd0, if_a.word_data}, {20'd0, q_a.pop_front()});
    end
    if (if_b.word_valid) begin
      if (q_b.size() == 0) check("b_unexpected_word", {31'd0, if_b.word_valid}, 32'd0);
      else                 check("b_word", {16'd0, if_b.word_data}, {16'd0, q_b.pop_front()});
    end
    if (if_c.word_valid) begin
      if (q_c.size() == 0) check("c_unexpected_word", {31'd0, if_c.word_valid}, 32'd0);
      else                 check("c_word", {20'd0, if_c.word_data}, {20'd0, q_c.pop_front()});
    end
  end

  initial begin
    if_a.byte_valid = 1'b0; if_a.byte_data = 8'h00; if_a.flush = 1'b0;
    if_b.byte_valid = 1'b0; if_b.byte_data = 8'h00; if_b.flush = 1'b0;
    if_c.byte_valid = 1'b0; if_c.byte_data = 8'h00; if_c.flush = 1'b0;

    idle(2);
    check("rst_word_data",   {20'd0, if_a.word_data}, 32'h0);
    check("rst_word_valid",  {31'd0, if_a.word_valid}, 32'd0);
    check("rst_busy",        {31'd0, if_a.busy}, 32'd0);
    check("rst_digit_count", {30'd0, if_a.digit_count}, 32'd0);
    check("rst_errors",      {30'd0, if_a.digit_error, if_a.timeout_error}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Default config: ASCII-looking bytes still decode from the low nibble.
    drive_a(8'h31, 1'b0);
    check("a_busy_after_first", {31'd0, if_a.busy}, 32'd1);
    check("a_count_after_first", {30'd0, if_a.digit_count}, 32'd1);
    drive_a(8'h32, 1'b0);
    check("a_no_early_valid", {31'd0, if_a.word_valid}, 32'd0);
    q_a.push_back(12'h321);
    drive_a(8'h33, 1'b0);
    check("a_valid_latency", {31'd0, if_a.word_valid}, 32'd1);
    check("a_word_321", {20'd0, if_a.word_data}, 32'h321);
    check("a_idle_after_word", {31'd0, if_a.busy}, 32'd0);
    tick();
    check("a_valid_one_cycle", {31'd0, if_a.word_valid}, 32'd0);
    check("a_word_held", {20'd0, if_a.word_data}, 32'h321);

    // Raw mode validation: 0x0A rejected, 0xF5 is digit 5.
    drive_a(8'h0A, 1'b0);
    check("a_digit_error_0A", {31'd0, if_a.digit_error}, 32'd1);
    check("a_count_after_err", {30'd0, if_a.digit_count}, 32'd0);
    check("a_busy_after_err", {31'd0, if_a.busy}, 32'd0);
    tick();
    check("a_digit_error_pulse", {31'd0, if_a.digit_error}, 32'd0);
    drive_a(8'hF5, 1'b0);
    check("a_F5_accepted", {31'd0, if_a.digit_error}, 32'd0);
    drive_a(8'h07, 1'b0);
    q_a.push_back(12'h875);
    drive_a(8'h38, 1'b0);
    check("a_word_875", {20'd0, if_a.word_data}, 32'h875);

    // Six back-to-back bytes: two words three cycles apart, no dead cycle.
    q_a.push_back(12'h321);
    q_a.push_back(12'h654);
    drive_a(8'h01, 1'b0);
    drive_a(8'h02, 1'b0);
    drive_a(8'h03, 1'b0);
    check("a_b2b_first_valid", {31'd0, if_a.word_valid}, 32'd1);
    drive_a(8'h04, 1'b0);
    check("a_b2b_gap_valid", {31'd0, if_a.word_valid}, 32'd0);
    check("a_b2b_next_count", {30'd0, if_a.digit_count}, 32'd1);
    drive_a(8'h05, 1'b0);
    drive_a(8'h06, 1'b0);
    check("a_b2b_second_valid", {31'd0, if_a.word_valid}, 32'd1);
    check("a_b2b_word_654", {20'd0, if_a.word_data}, 32'h654);

    // Flush beats the simultaneous second byte.
    drive_a(8'h07, 1'b0);
    drive_a(8'h08, 1'b1);
    check("a_flush_busy", {31'd0, if_a.busy}, 32'd0);
    check("a_flush_count", {30'd0, if_a.digit_count}, 32'd0);
    check("a_flush_no_pulse", {29'd0, if_a.word_valid, if_a.digit_error, if_a.timeout_error}, 32'd0);
    check("a_flush_word_held", {20'd0, if_a.word_data}, 32'h654);
    drive_a(8'h09, 1'b0);
    drive_a(8'h01, 1'b0);
    q_a.push_back(12'h219);
    drive_a(8'h02, 1'b0);
    check("a_after_flush_word", {20'd0, if_a.word_data}, 32'h219);

    // MSD-first ASCII four-digit word with spaced bytes.
    drive_b(8'h39);
    idle(9);
    drive_b(8'h30);
    idle(9);
    drive_b(8'h34);
    idle(9);
    check("b_count_3", {29'd0, if_b.digit_count}, 32'd3);
    q_b.push_back(16'h9047);
    drive_b(8'h37);
    check("b_word_9047", {16'd0, if_b.word_data}, 32'h9047);
    tick();
    drive_b(8'h31);
    drive_b(8'h32);
    drive_b(8'h41);
    check("b_digit_error_41", {31'd0, if_b.digit_error}, 32'd1);
    check("b_count_after_err", {29'd0, if_b.digit_count}, 32'd0);
    check("b_word_unchanged", {16'd0, if_b.word_data}, 32'h9047);
    drive_b(8'h05);
    check("b_raw_rejected", {31'd0, if_b.digit_error}, 32'd1);
    drive_b(8'h3A);
    check("b_3A_rejected", {31'd0, if_b.digit_error}, 32'd1);
    check("b_idle_after_rejects", {31'd0, if_b.busy}, 32'd0);

    // Timeout of 8: error registered on the 8th silent edge.
    drive_c(8'h01);
    drive_c(8'h02);
    for (int k = 1; k <= 7; k++) begin
      tick();
      check($sformatf("c_no_timeout_%0d", k), {31'd0, if_c.timeout_error}, 32'd0);
    end
    check("c_busy_waiting", {31'd0, if_c.busy}, 32'd1);
    tick();
    check("c_timeout_pulse", {31'd0, if_c.timeout_error}, 32'd1);
    check("c_timeout_idle", {31'd0, if_c.busy}, 32'd0);
    check("c_timeout_count", {30'd0, if_c.digit_count}, 32'd0);
    check("c_timeout_word_held", {20'd0, if_c.word_data}, 32'h0);
    tick();
    check("c_timeout_one_cycle", {31'd0, if_c.timeout_error}, 32'd0);

    // Byte landing in the last allowed cycle still counts.
    drive_c(8'h03);
    drive_c(8'h04);
    idle(7);
    q_c.push_back(12'h543);
    drive_c(8'h05);
    check("c_edge_byte_no_timeout", {31'd0, if_c.timeout_error}, 32'd0);
    check("c_edge_byte_word", {20'd0, if_c.word_data}, 32'h543);

    // Asynchronous reset mid-word, between clock edges.
    tick();
    drive_a(8'h03, 1'b0);
    drive_a(8'h04, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_word", {20'd0, if_a.word_data}, 32'h0);
    check("async_rst_busy_count", {29'd0, if_a.busy, if_a.digit_count}, 32'd0);
    check("async_rst_pulses", {29'd0, if_a.word_valid, if_a.digit_error, if_a.timeout_error}, 32'd0);
    #3;
    rst = 1'b0;
    drive_a(8'h05, 1'b0);
    drive_a(8'h06, 1'b0);
    q_a.push_back(12'h765);
    drive_a(8'h07, 1'b0);
    check("post_rst_word", {20'd0, if_a.word_data}, 32'h765);

    idle(2);
    check("a_queue_drained", q_a.size(), 32'd0);
    check("b_queue_drained", q_b.size(), 32'd0);
    check("c_queue_drained", q_c.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_bcd_word_assembler.md
Name: uart_bcd_word_assembler

Overview:
Generalised BCD word assembler that sits directly after the UART byte receiver.
- Consumes received bytes (byte_valid strobe + byte_data) and extracts one decimal digit per byte.
- Packs N_DIGITS digits into a 4*N_DIGITS-bit BCD word and publishes it with a one-cycle word_valid pulse.
- Adds digit validation, configurable digit order, ASCII/raw decoding, inter-byte timeout, flush, and a double-buffered output so partial words are never visible downstream.

Parameters:
N_DIGITS, 3, number of BCD digits per word (>=1); word width W = 4*N_DIGITS.
MSD_FIRST, 0, 0: first received digit lands in bits [3:0], each later digit 4 bits higher; 1: first digit lands in bits [W-1:W-4], each later digit 4 bits lower.
ASCII_MODE, 0, 0: digit = byte_data[3:0], upper nibble ignored; 1: only 0x30..0x39 accepted, digit = byte_data[3:0].
TIMEOUT_CYCLES, 0, 0 disables timeout; else partial word aborted after this many consecutive clk cycles in COLLECT without byte_valid.

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  asynchronous, active-high reset
byte_valid  in  1  one-cycle strobe, byte_data valid this cycle
byte_data  in  8  received byte
flush  in  1  synchronous abort of any partial word
word_data  out  W  last complete BCD word, held until next completion
word_valid  out  1  one-cycle pulse, word_data updated this cycle
digit_error  out  1  one-cycle pulse, invalid byte caused abort
timeout_error  out  1  one-cycle pulse, inter-byte timeout caused abort
busy  out  1  high while in COLLECT
digit_count  out  clog2(N_DIGITS+1)  digits accepted into current partial word

Behaviour:
- Reset, asynchronous: state=IDLE; word_data=0; word_valid=0; digit_error=0; timeout_error=0; busy=0; digit_count=0; shift/partial register=0; timer=0.
- All outputs are registered. Pulse outputs default to 0 every cycle unless set below.
- Valid digit:
  - ASCII_MODE=0: byte_data[3:0] <= 9.
  - ASCII_MODE=1: byte_data in 0x30..0x39.
- FSM states: IDLE, COLLECT.
- IDLE:
  - byte_valid with a valid digit: store the digit in position 0 (order per MSD_FIRST); digit_count=1; go COLLECT.
  - N_DIGITS=1: the word completes immediately instead (see completion rule); stay IDLE.
  - byte_valid with an invalid digit: digit_error pulse; stay IDLE; digit_count stays 0.
- COLLECT:
  - Valid digit: stored at position digit_count; digit_count+1; timer=0.
  - Invalid digit: partial discarded; digit_count=0; digit_error pulse; go IDLE.
- Completion: the edge that accepts digit N_DIGITS:
  - loads word_data with the full word (including that digit) and sets word_valid=1 for exactly one cycle;
  - clears digit_count and the partial register; goes IDLE.
  - Latency: word_valid is high in the cycle immediately after the cycle where the last byte_valid was high.
- Back-to-back bytes: byte_valid may be high every cycle; every byte is processed, with no dead cycle after completion. The cycle after completion may already accept digit 0 of the next word.
- Timeout (TIMEOUT_CYCLES>0, COLLECT only):
  - timer increments on each cycle without byte_valid.
  - If timer==TIMEOUT_CYCLES-1 and no byte_valid in that cycle: discard partial; timeout_error pulse; go IDLE.
  - byte_valid in that same cycle is accepted normally; no timeout.
- flush: IDLE/COLLECT -> IDLE, partial and digit_count cleared, no error pulse, word_data unchanged.
  - flush has priority over a simultaneous byte_valid; that byte is dropped.
- word_data changes only on completion or reset. Aborts (error, timeout, flush) never alter it.
- busy == (state==COLLECT).
- Reset asserted mid-word: everything is cleared immediately. The first byte after deassertion starts a new word.

Test Plan:
- Defaults; bytes 0x31,0x32,0x33 on consecutive cycles -> one cycle later word_valid=1, word_data=12'h321; next cycle word_valid=0, word_data held at 12'h321.
- MSD_FIRST=1, ASCII_MODE=1, N_DIGITS=4; bytes "9","0","4","7" spaced 10 cycles apart -> word_data=16'h9047 with a single word_valid pulse; a byte 0x41 mid-word -> digit_error pulse, digit_count=0, word_data unchanged.
- ASCII_MODE=0: byte 0x0A -> digit_error; byte 0xF5 accepted as digit 5.
- TIMEOUT_CYCLES=8: two digits, then silence -> timeout_error pulses exactly 8 cycles after the last byte_valid; a third byte arriving exactly on cycle 8 -> no timeout, word completes.
- Six valid bytes back-to-back, N_DIGITS=3 -> two word_valid pulses 3 cycles apart with the correct words; flush asserted together with byte 2 of a word -> byte dropped, busy=0 next cycle, no pulses.
- reset asserted asynchronously between clock edges after 2 digits -> all outputs 0 immediately; 3 new digits after release -> correct word, with no contamination from the earlier partial.
